pacman_vram_fetch: RTL
======================

Name: pacman_vram_fetch

Overview:
GPU-side requester for the framebuffer read port owned by the memory manager. It walks the tile and colour RAM (0x4000–0x43FF codes, 0x4400–0x47FF colours) once per frame. It drives the two GPU address buses, captures the returned bytes after a fixed read latency, and queues {index, code, colour} records in a small FIFO for the pixel pipeline. An address value of 0 means "no GPU read", which releases the framebuffer to the CPU.

Parameters:
NUM_TILES, 1008, number of tiles fetched per frame (28x36 playfield); must be ≤ 1024.
RD_LAT, 2, cycles from address presented to data valid on fb_douta/fb_doutb; must be ≥ 1.
FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and ≥ 2.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
frame_start  in  1  single-cycle pulse; begins a frame fetch
flip_screen  in  1  reverse tile order (used only with the optional feature)
gpu_addr_out1  out  16  tile-code address to memory manager; 0 when idle
gpu_addr_out2  out  16  colour address to memory manager; 0 when idle
fb_douta  in  8  framebuffer port A read data (tile code)
fb_doutb  in  8  framebuffer port B read data (colour)
tile_valid  out  1  FIFO head valid
tile_ready  in  1  consumer accepts head
tile_idx  out  10  head tile index
tile_code  out  8  head tile code
tile_color  out  8  head colour byte
busy  out  1  high from frame accept until frame done
frame_done  out  1  one-cycle pulse after the last tile is pushed
frame_overrun  out  1  one-cycle pulse when frame_start arrives while busy

Behaviour:
- Reset (async): state IDLE, idx=0, latency counter=0, FIFO empty. All outputs are 0.
- States:
  - IDLE: addresses are 0. On frame_start: idx←0, busy←1. Go to ISSUE if the FIFO is not full, else STALL.
  - ISSUE: gpu_addr_out1=0x4000+a, gpu_addr_out2=0x4400+a, where a = physical index (10 bits, zero-extended). Addresses are held for RD_LAT cycles, then go to CAPTURE.
  - CAPTURE: addresses are still held. Sample fb_douta/fb_doutb and push {idx, code, colour} to the FIFO.
    - If idx==NUM_TILES-1: go to DONE.
    - Else idx←idx+1. Go to ISSUE if the FIFO count after the push and pop is < FIFO_DEPTH, else STALL.
  - STALL: addresses are 0 (bus released). Go to ISSUE when the FIFO is not full.
  - DONE: frame_done=1 for this single cycle, busy←0, go to IDLE. The FIFO keeps draining independently.
- Timing and throughput:
  - One tile is in flight at a time, so CAPTURE never finds the FIFO full.
  - RD_LAT+1 cycles per tile with no backpressure: 3024 cycles per frame at the defaults.
  - First record is visible at the FIFO head (tile_valid=1) on the cycle after the first CAPTURE.
- FIFO:
  - Synchronous, registered head outputs. Pop when tile_valid && tile_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Push on empty: the head is valid on the next cycle; there is no fall-through.
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
  - tile_idx/code/color hold their values while tile_valid=0.
- Concurrent events:
  - frame_start while busy, including on the DONE cycle: ignored and frame_overrun pulses.
  - frame_start on the cycle after DONE is accepted normally.
- Memory manager coupling:
  - Addresses never equal 0 while a read is intended; the minimum is 0x4000.
  - The block never waits on CPU arbitration; the memory manager gives the GPU priority.

Optional Feature:
FETCH_FLIP_EN
- Defined: when flip_screen is sampled 1 at frame_start, the physical index is a = NUM_TILES-1-idx for that whole frame. tile_idx still reports the logical idx. flip_screen changes mid-frame are ignored.
- Undefined: flip_screen is unused and a = idx always.

Test Plan:
1. Reset, frame_start, tile_ready=1, memory model returns code=idx[7:0], colour=~idx[7:0] after RD_LAT=2:
   - first addresses are 0x4000/0x4400;
   - 1008 records in order;
   - last record has idx=1007, addr1=0x43EF;
   - frame_done pulses once;
   - busy is low afterwards.
2. Backpressure: tile_ready=0 for 20 cycles mid-frame:
   - after 4 pushes, state is STALL with both addresses 0;
   - no records are lost or duplicated after release;
   - order is preserved.
3. frame_start pulsed at cycle 100 of a frame:
   - frame_overrun pulses for 1 cycle;
   - the fetch sequence is unaffected;
   - the total is still 1008 records.
4. reset_n asserted mid-frame at idx=500:
   - all outputs are 0 immediately (asynchronously);
   - after release plus frame_start, fetch restarts at idx=0, addr 0x4000.
5. FIFO boundary: alternate tile_ready so push and pop coincide with count=FIFO_DEPTH-1:
   - count stays constant;
   - head data matches the expected sequence;
   - tile_valid never glitches low.
6. With FETCH_FLIP_EN defined and flip_screen=1 at frame_start:
   - first addr1=0x43EF, addr2=0x47EF, tile_idx=0;
   - final addr1=0x4000.

Source files
------------

// File: rtl/pacman_vram_fetch_if.sv
// rtl/pacman_vram_fetch_if.sv - framebuffer read bus plus tile record stream between fetcher and its peers
interface pacman_vram_fetch_if;
    logic [15:0] gpu_addr_out1;
    logic [15:0] gpu_addr_out2;
    logic [7:0]  fb_douta;
    logic [7:0]  fb_doutb;
    logic        tile_valid;
    logic        tile_ready;
    logic [9:0]  tile_idx;
    logic [7:0]  tile_code;
    logic [7:0]  tile_color;

    modport master (
        output gpu_addr_out1, gpu_addr_out2,
        input  fb_douta, fb_doutb,
        output tile_valid, tile_idx, tile_code, tile_color,
        input  tile_ready
    );

    modport slave (
        input  gpu_addr_out1, gpu_addr_out2,
        output fb_douta, fb_doutb,
        input  tile_valid, tile_idx, tile_code, tile_color,
        output tile_ready
    );
endinterface

// File: rtl/pacman_vram_fetch.sv
// rtl/pacman_vram_fetch.sv - per-frame tile/colour RAM fetch requester with record FIFO
// Optional reversed tile order under `define FETCH_FLIP_EN.
module pacman_vram_fetch #(
    parameter int NUM_TILES  = 1008,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic                 flip_screen,
    pacman_vram_fetch_if.master  bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 frame_overrun
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [9:0]    LAST_IDX = 10'(NUM_TILES - 1);
    localparam logic [LW-1:0] LAT_END  = LW'(RD_LAT - 1);
    localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] STALL   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]    state;
    logic [9:0]    idx;
    logic [9:0]    phys;
    logic [LW-1:0] lat_cnt;

    logic [25:0]   mem [FIFO_DEPTH];
    logic [25:0]   head;
    logic [25:0]   push_data;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          full;
    logic          bus_active;

`ifdef FETCH_FLIP_EN
    // Orientation is latched once per frame so mid-frame flips cannot tear the fetch order.
    logic flip;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            flip <= 1'b0;
        else if (state == IDLE && frame_start)
            flip <= flip_screen;
    end
    assign phys = flip ? (LAST_IDX - idx) : idx;
`else
    logic unused_flip;
    assign unused_flip = flip_screen;
    assign phys = idx;
`endif

    assign push       = (state == CAPTURE);
    assign pop        = bus.tile_valid && bus.tile_ready;
    assign full       = (count == DEPTH);
    assign push_data  = {idx, bus.fb_douta, bus.fb_doutb};
    assign rd_next    = rd_ptr + 1'b1;
    assign bus_active = (state == ISSUE) || (state == CAPTURE);

    // Address 0 hands the framebuffer back to the CPU, so it is only driven outside a read.
    assign bus.gpu_addr_out1 = bus_active ? (16'h4000 + {6'd0, phys}) : 16'h0000;
    assign bus.gpu_addr_out2 = bus_active ? (16'h4400 + {6'd0, phys}) : 16'h0000;
    assign bus.tile_valid    = (count != '0);
    assign bus.tile_idx      = head[25:16];
    assign bus.tile_code     = head[15:8];
    assign bus.tile_color    = head[7:0];

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            idx           <= '0;
            lat_cnt       <= '0;
            frame_overrun <= 1'b0;
        end else begin
            frame_overrun <= frame_start && (state != IDLE);
            case (state)
                IDLE: if (frame_start) begin
                    idx     <= '0;
                    lat_cnt <= '0;
                    state   <= full ? STALL : ISSUE;
                end
                ISSUE: if (lat_cnt == LAT_END) begin
                    lat_cnt <= '0;
                    state   <= CAPTURE;
                end else begin
                    lat_cnt <= lat_cnt + 1'b1;
                end
                CAPTURE: if (idx == LAST_IDX) begin
                    state <= DONE;
                end else begin
                    idx   <= idx + 1'b1;
                    state <= (count_next < DEPTH) ? ISSUE : STALL;
                end
                STALL: if (!full) state <= ISSUE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Head is a separate register so it holds its last value once the FIFO empties.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_next;
            count <= count_next;
            if (pop) begin
                if (count > CW'(1))
                    head <= mem[rd_next];
                else if (push)
                    head <= push_data;
            end else if (count == '0 && push) begin
                head <= push_data;
            end
        end
    end
endmodule
